// File: rtl/moore_machine.sv
// Moore-type serial detector for the bit pattern 1100 (oldest first), overlapping matches allowed.
// The y flag is registered and decoded from the next state, so it never follows x or enable combinationally.
module moore_machine (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       enable,
    output logic       y,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S11  = 3'd2,
        S110 = 3'd3,
        DET  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   y_q, y_d;

    // Unknown codes fall back to IDLE on the next enabled edge; a disabled edge holds everything.
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                IDLE:    state_d = x ? S1  : IDLE;
                S1:      state_d = x ? S11 : IDLE;
                S11:     state_d = x ? S11 : S110;
                S110:    state_d = x ? S1  : DET;
                DET:     state_d = x ? S1  : IDLE;
                default: state_d = IDLE;
            endcase
        end
        y_d = (state_d == DET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_moore_machine.sv
// Directed bench for moore_machine: each scenario task drives bits and checks y and the state inline.
module tb_moore_machine;

    logic       clk;
    logic       reset;
    logic       x;
    logic       enable;
    logic       y;
    logic [2:0] state_dbg;

    int errors;
    int checks;

    moore_machine dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .enable    (enable),
        .y         (y),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input logic en);
        @(negedge clk);
        x      = b;
        enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic b[6];
        logic e[6];
        b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset  = 1'b1;
        x      = 1'b0;
        enable = 1'b0;
        #3;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL reset_y: got %b want 0", y);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        #4;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_bit(b[i], 1'b1);
            checks++;
            if (y !== e[i]) begin
                errors++;
                $display("FAIL basic_detect bit%0d: got y=%b want %b", i + 1, y, e[i]);
            end
        end
        drive_bit(1'b0, 1'b1);
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got y=%b want 0", y);
        end
    endtask

    task automatic test_back_to_back();
        logic b[8];
        logic e[8];
        b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], 1'b1);
            checks++;
            if (y !== e[i]) begin
                errors++;
                $display("FAIL back_to_back bit%0d: got y=%b want %b", i + 1, y, e[i]);
            end
        end
    endtask

    task automatic test_long_ones();
        logic       b[7];
        logic       e[7];
        logic [2:0] s[7];
        b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        s = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_bit(b[i], 1'b1);
            checks++;
            if (y !== e[i]) begin
                errors++;
                $display("FAIL long_ones_y bit%0d: got %b want %b", i + 1, y, e[i]);
            end
            checks++;
            if (state_dbg !== s[i]) begin
                errors++;
                $display("FAIL long_ones_state bit%0d: got %0d want %0d", i + 1, state_dbg, s[i]);
            end
        end
    endtask

    task automatic test_near_miss();
        logic       b1[6];
        logic [2:0] s1[6];
        logic       b2[4];
        b1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        s1 = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0};
        b2 = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_bit(b1[i], 1'b1);
            checks++;
            if (y !== 1'b0 || state_dbg !== s1[i]) begin
                errors++;
                $display("FAIL near_miss_a bit%0d: got y=%b st=%0d want y=0 st=%0d",
                         i + 1, y, state_dbg, s1[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_bit(b2[i], 1'b1);
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("FAIL near_miss_b bit%0d: got y=%b want 0", i + 1, y);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic b[4];
        b = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b1);
        checks++;
        if (y !== 1'b1) begin
            errors++;
            $display("FAIL enable_pre_detect: got y=%b want 1", y);
        end
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b1, 1'b0);
            checks++;
            if (y !== 1'b1 || state_dbg !== 3'd4) begin
                errors++;
                $display("FAIL enable_hold cyc%0d: got y=%b st=%0d want y=1 st=4", i, y, state_dbg);
            end
        end
        drive_bit(1'b0, 1'b1);
        checks++;
        if (y !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL enable_release: got y=%b st=%0d want y=0 st=0", y, state_dbg);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        checks++;
        if (state_dbg !== 3'd3) begin
            errors++;
            $display("FAIL async_pre_state: got %0d want 3", state_dbg);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL async_mid: got y=%b st=%0d want y=0 st=0", y, state_dbg);
        end
        #1;
        reset = 1'b0;
        drive_bit(1'b0, 1'b1);
        checks++;
        if (y !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL async_after: got y=%b st=%0d want y=0 st=0", y, state_dbg);
        end
        // reset while the flag is high must drop it in the same step
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL async_in_det: got y=%b st=%0d want y=0 st=0", y, state_dbg);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL async_held_edge: got st=%0d want 0", state_dbg);
        end
        reset = 1'b0;
        drive_bit(1'b1, 1'b1);
        checks++;
        if (state_dbg !== 3'd1 || y !== 1'b0) begin
            errors++;
            $display("FAIL async_first_edge: got y=%b st=%0d want y=0 st=1", y, state_dbg);
        end
    endtask

    // scenario sequence and final report
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_back_to_back();
        test_long_ones();
        test_near_miss();
        test_enable_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
